mult_result_checker: RTL and testbench

- Synthesizable response-side block for the 8x8 unsigned `mult` datapath.
- Accepts (a, b, p) result triples and checks each p against a locally computed a*b.
- Keeps pass/fail counts and logs every triple, with its mismatch flag, in a FIFO that a host drains with a read handshake.
- It is the on-chip replacement for file-based result logging and sits directly downstream of `mult` in the self-test path.

---
 rtl/mult_result_checker.sv | 145 ++++++++++++++
 tb/tb_mult_result_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_checker.sv
// mult_result_checker: response-side checker for the 8x8 unsigned mult datapath.
// Recomputes a*b for each accepted triple, keeps pass/fail counts and logs
// every triple with its mismatch flag in a FIFO drained by a host read port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; triples ignored until start
// CAPTURE | accepting one triple per cycle with in_valid, until NUM_VEC
// DONE    | run complete; counts and log held until start or rst
module mult_result_checker #(
  parameter int DEPTH   = 4,
  parameter int NUM_VEC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [15:0] in_p,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [32:0] rd_data,
  output logic        empty,
  output logic        full,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_count,
  output logic [7:0]  fail_count,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   OCC_ONE  = 1;
  localparam logic [AW:0]   OCC_ZERO = 0;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]    ACC_LAST = 8'(NUM_VEC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        state;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [7:0]    acc_count;

  logic [15:0]   expected;
  logic          mismatch;
  logic          accept;
  logic          pop;
  logic          push;
  logic          drop;
  logic [AW:0]   occ_next;
  logic [7:0]    acc_next;

  // Compare, accept/push/pop qualification and next occupancy for this cycle.
  // A pop frees a slot in the same cycle, so a push into a full FIFO that is
  // also being popped is accepted rather than dropped.
  always_comb begin
    expected = {8'b0, in_a} * {8'b0, in_b};
    mismatch = (in_p != expected);
    accept   = !start && (state == S_CAPTURE) && in_valid;
    pop      = !start && rd_en && !empty;
    push     = accept && (!full || pop);
    drop     = accept && full && !pop;
    acc_next = acc_count + 8'd1;
    occ_next = occ;
    if (push && !pop)
      occ_next = occ + OCC_ONE;
    else if (pop && !push)
      occ_next = occ - OCC_ONE;
  end

  // Log storage; stale contents are harmless because pointers gate access.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= {mismatch, in_a, in_b, in_p};
  end

  // Run FSM, counters, FIFO pointers/flags and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      acc_count  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else if (start) begin
      state      <= S_CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      acc_count  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      occ   <= occ_next;
      empty <= (occ_next == OCC_ZERO);
      full  <= (occ_next == OCC_FULL);
      if (drop)
        overflow <= 1'b1;
      if (accept) begin
        if (mismatch)
          fail_count <= fail_count + 8'd1;
        else
          pass_count <= pass_count + 8'd1;
        acc_count <= acc_next;
        if (acc_next == ACC_LAST) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_result_checker.sv
// Directed bench for mult_result_checker. Two instances share stimulus:
// d0 uses defaults (DEPTH=4, NUM_VEC=4), d1 uses NUM_VEC=6 for overflow
// and full push+pop scenarios. Outputs are sampled on the falling edge.
module tb_mult_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [15:0] in_p = '0;
  logic        rd_en = 1'b0;

  logic        d0_rd_valid, d0_empty, d0_full, d0_busy, d0_done, d0_overflow;
  logic [32:0] d0_rd_data;
  logic [7:0]  d0_pass, d0_fail;
  logic        d1_rd_valid, d1_empty, d1_full, d1_busy, d1_done, d1_overflow;
  logic [32:0] d1_rd_data;
  logic [7:0]  d1_pass, d1_fail;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_result_checker #(.DEPTH(4), .NUM_VEC(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .rd_en(rd_en),
    .rd_valid(d0_rd_valid), .rd_data(d0_rd_data), .empty(d0_empty),
    .full(d0_full), .busy(d0_busy), .done(d0_done),
    .pass_count(d0_pass), .fail_count(d0_fail), .overflow(d0_overflow)
  );

  mult_result_checker #(.DEPTH(4), .NUM_VEC(6)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .rd_en(rd_en),
    .rd_valid(d1_rd_valid), .rd_data(d1_rd_data), .empty(d1_empty),
    .full(d1_full), .busy(d1_busy), .done(d1_done),
    .pass_count(d1_pass), .fail_count(d1_fail), .overflow(d1_overflow)
  );

  // Apply one cycle of stimulus and return on the following falling edge.
  task automatic drive(input logic s, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] p, input logic r);
    start = s; in_valid = v; in_a = a; in_b = b; in_p = p; rd_en = r;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 0);
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 0);
    rst = 1'b0;
    checks++; if (d0_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", d0_rd_valid); end
    checks++; if (d0_rd_data !== 33'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0", d0_rd_data); end
    checks++; if (d0_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", d0_empty); end
    checks++; if (d0_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", d0_full); end
    checks++; if (d0_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", d0_busy); end
    checks++; if (d0_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", d0_done); end
    checks++; if (d0_pass !== 8'd0) begin failures++; $display("FAIL rst_pass got=%0d exp=0", d0_pass); end
    checks++; if (d0_fail !== 8'd0) begin failures++; $display("FAIL rst_fail got=%0d exp=0", d0_fail); end
    checks++; if (d0_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", d0_overflow); end
  endtask

  task automatic test_basic;
    logic [7:0]  va [4] = '{8'h02, 8'hff, 8'h00, 8'h80};
    logic [7:0]  vb [4] = '{8'h03, 8'hff, 8'h5a, 8'h02};
    logic [15:0] vp [4] = '{16'h0006, 16'hfe01, 16'h0000, 16'h0100};
    drive(1, 0, 8'h00, 8'h00, 16'h0000, 0);
    checks++; if (d0_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", d0_busy); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, va[i], vb[i], vp[i], 0);
      if (i == 2) begin
        checks++; if (d0_done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", d0_done); end
      end
    end
    checks++; if (d0_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", d0_done); end
    checks++; if (d0_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", d0_busy); end
    checks++; if (d0_pass !== 8'd4) begin failures++; $display("FAIL basic_pass got=%0d exp=4", d0_pass); end
    checks++; if (d0_fail !== 8'd0) begin failures++; $display("FAIL basic_fail got=%0d exp=0", d0_fail); end
    checks++; if (d0_full !== 1'b1) begin failures++; $display("FAIL basic_full got=%b exp=1", d0_full); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
      checks++; if (d0_rd_valid !== 1'b1) begin failures++; $display("FAIL basic_rd_valid[%0d] got=%b exp=1", i, d0_rd_valid); end
      checks++; if (d0_rd_data !== {1'b0, va[i], vb[i], vp[i]}) begin failures++; $display("FAIL basic_rd_data[%0d] got=%h exp=%h", i, d0_rd_data, {1'b0, va[i], vb[i], vp[i]}); end
    end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 0);
    checks++; if (d0_rd_valid !== 1'b0) begin failures++; $display("FAIL basic_rd_valid_drop got=%b exp=0", d0_rd_valid); end
    checks++; if (d0_empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", d0_empty); end
    checks++; if (d0_rd_data !== 33'h0_8002_0100) begin failures++; $display("FAIL basic_rd_hold got=%h exp=%h", d0_rd_data, 33'h0_8002_0100); end
  endtask

  task automatic test_mismatch;
    drive(1, 0, 8'h00, 8'h00, 16'h0000, 0);
    checks++; if (d0_pass !== 8'd0 || d0_fail !== 8'd0) begin failures++; $display("FAIL mm_clear got=%0d/%0d exp=0/0", d0_pass, d0_fail); end
    checks++; if (d0_done !== 1'b0) begin failures++; $display("FAIL mm_done_clear got=%b exp=0", d0_done); end
    drive(0, 1, 8'h10, 8'h10, 16'h0101, 0);
    drive(0, 1, 8'h03, 8'h04, 16'h000c, 0);
    drive(0, 1, 8'h07, 8'h09, 16'h003f, 0);
    drive(0, 1, 8'h0f, 8'h11, 16'h00ff, 0);
    checks++; if (d0_fail !== 8'd1) begin failures++; $display("FAIL mm_fail got=%0d exp=1", d0_fail); end
    checks++; if (d0_pass !== 8'd3) begin failures++; $display("FAIL mm_pass got=%0d exp=3", d0_pass); end
    checks++; if (d0_done !== 1'b1) begin failures++; $display("FAIL mm_done got=%b exp=1", d0_done); end
    drive(0, 1, 8'h01, 8'h01, 16'h0000, 0);
    checks++; if (d0_pass !== 8'd3 || d0_fail !== 8'd1) begin failures++; $display("FAIL done_ignore got=%0d/%0d exp=3/1", d0_pass, d0_fail); end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
    checks++; if (d0_rd_data !== 33'h1_1010_0101) begin failures++; $display("FAIL mm_rd0 got=%h exp=%h", d0_rd_data, 33'h1_1010_0101); end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
    checks++; if (d0_rd_data !== 33'h0_0304_000c) begin failures++; $display("FAIL mm_rd1 got=%h exp=%h", d0_rd_data, 33'h0_0304_000c); end
  endtask

  task automatic test_overflow;
    logic [7:0] k;
    drive(1, 0, 8'h00, 8'h00, 16'h0000, 0);
    for (int i = 0; i < 6; i++) begin
      k = 8'(i + 1);
      drive(0, 1, k, k, {8'h00, k} * {8'h00, k}, 0);
      if (i == 3) begin
        checks++; if (d1_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", d1_full); end
        checks++; if (d1_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", d1_overflow); end
      end
      if (i == 4) begin
        checks++; if (d1_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", d1_overflow); end
      end
    end
    checks++; if (d1_pass !== 8'd6) begin failures++; $display("FAIL ovf_pass got=%0d exp=6", d1_pass); end
    checks++; if (d1_done !== 1'b1) begin failures++; $display("FAIL ovf_done got=%b exp=1", d1_done); end
    for (int i = 1; i <= 4; i++) begin
      k = 8'(i);
      drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
      checks++; if (d1_rd_data !== {1'b0, k, k, {8'h00, k} * {8'h00, k}}) begin failures++; $display("FAIL ovf_rd[%0d] got=%h", i, d1_rd_data); end
    end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
    checks++; if (d1_rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_rd_empty got=%b exp=0", d1_rd_valid); end
    checks++; if (d1_empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", d1_empty); end
  endtask

  task automatic test_push_pop_full;
    logic [7:0] k;
    drive(1, 0, 8'h00, 8'h00, 16'h0000, 0);
    for (int i = 1; i <= 4; i++) begin
      k = 8'(i);
      drive(0, 1, k, k, {8'h00, k} * {8'h00, k}, 0);
    end
    checks++; if (d1_full !== 1'b1) begin failures++; $display("FAIL pp_full_pre got=%b exp=1", d1_full); end
    drive(0, 1, 8'h07, 8'h07, 16'h0031, 1);
    checks++; if (d1_rd_valid !== 1'b1) begin failures++; $display("FAIL pp_rd_valid got=%b exp=1", d1_rd_valid); end
    checks++; if (d1_rd_data !== 33'h0_0101_0001) begin failures++; $display("FAIL pp_rd_data got=%h exp=%h", d1_rd_data, 33'h0_0101_0001); end
    checks++; if (d1_full !== 1'b1) begin failures++; $display("FAIL pp_full got=%b exp=1", d1_full); end
    checks++; if (d1_overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b exp=0", d1_overflow); end
    checks++; if (d1_pass !== 8'd5) begin failures++; $display("FAIL pp_pass got=%0d exp=5", d1_pass); end
    for (int i = 2; i <= 4; i++) begin
      k = 8'(i);
      drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
      checks++; if (d1_rd_data !== {1'b0, k, k, {8'h00, k} * {8'h00, k}}) begin failures++; $display("FAIL pp_rd[%0d] got=%h", i, d1_rd_data); end
    end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
    checks++; if (d1_rd_data !== 33'h0_0707_0031) begin failures++; $display("FAIL pp_rd_new got=%h exp=%h", d1_rd_data, 33'h0_0707_0031); end
    checks++; if (d1_empty !== 1'b1) begin failures++; $display("FAIL pp_empty got=%b exp=1", d1_empty); end
  endtask

  task automatic test_ignore_rules;
    rst = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 0);
    rst = 1'b0;
    drive(0, 1, 8'h02, 8'h03, 16'h0006, 0);
    checks++; if (d0_pass !== 8'd0 || d0_empty !== 1'b1) begin failures++; $display("FAIL idle_ignore got=%0d/%b exp=0/1", d0_pass, d0_empty); end
    drive(1, 0, 8'h00, 8'h00, 16'h0000, 0);
    drive(0, 1, 8'h02, 8'h03, 16'h0006, 0);
    drive(0, 1, 8'h05, 8'h05, 16'h0019, 0);
    checks++; if (d0_pass !== 8'd2) begin failures++; $display("FAIL ign_pass2 got=%0d exp=2", d0_pass); end
    drive(1, 1, 8'h01, 8'h01, 16'h0001, 1);
    checks++; if (d0_pass !== 8'd0 || d0_fail !== 8'd0) begin failures++; $display("FAIL start_prio_counts got=%0d/%0d exp=0/0", d0_pass, d0_fail); end
    checks++; if (d0_empty !== 1'b1 || d0_busy !== 1'b1) begin failures++; $display("FAIL start_prio_flags got=%b/%b exp=1/1", d0_empty, d0_busy); end
    checks++; if (d0_rd_valid !== 1'b0) begin failures++; $display("FAIL start_prio_rd got=%b exp=0", d0_rd_valid); end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
    checks++; if (d0_rd_valid !== 1'b0) begin failures++; $display("FAIL rd_empty got=%b exp=0", d0_rd_valid); end
    drive(0, 1, 8'h0a, 8'h0b, 16'h006e, 0);
    checks++; if (d0_pass !== 8'd1) begin failures++; $display("FAIL post_start_pass got=%0d exp=1", d0_pass); end
    drive(0, 0, 8'h00, 8'h00, 16'h0000, 1);
    checks++; if (d0_rd_data !== 33'h0_0a0b_006e) begin failures++; $display("FAIL post_start_rd got=%h exp=%h", d0_rd_data, 33'h0_0a0b_006e); end
  endtask

  task automatic test_reset_mid_run;
    drive(1, 0, 8'h00, 8'h00, 16'h0000, 0);
    drive(0, 1, 8'h02, 8'h03, 16'h0006, 0);
    drive(0, 1, 8'h04, 8'h04, 16'h0000, 0);
    checks++; if (d0_pass !== 8'd1 || d0_fail !== 8'd1) begin failures++; $display("FAIL mid_pre got=%0d/%0d exp=1/1", d0_pass, d0_fail); end
    rst = 1'b1;
    drive(0, 1, 8'h03, 8'h03, 16'h0009, 1);
    rst = 1'b0;
    checks++; if (d0_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rd_valid got=%b exp=0", d0_rd_valid); end
    checks++; if (d0_rd_data !== 33'h0) begin failures++; $display("FAIL mid_rd_data got=%h exp=0", d0_rd_data); end
    checks++; if (d0_empty !== 1'b1 || d0_full !== 1'b0) begin failures++; $display("FAIL mid_fifo got=%b/%b exp=1/0", d0_empty, d0_full); end
    checks++; if (d0_busy !== 1'b0 || d0_done !== 1'b0) begin failures++; $display("FAIL mid_state got=%b/%b exp=0/0", d0_busy, d0_done); end
    checks++; if (d0_pass !== 8'd0 || d0_fail !== 8'd0) begin failures++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", d0_pass, d0_fail); end
    checks++; if (d0_overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow got=%b exp=0", d0_overflow); end
    drive(0, 1, 8'h03, 8'h03, 16'h0009, 0);
    checks++; if (d0_pass !== 8'd0 || d0_empty !== 1'b1 || d0_busy !== 1'b0) begin failures++; $display("FAIL mid_ignore got=%0d/%b/%b exp=0/1/0", d0_pass, d0_empty, d0_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_overflow();
    test_push_pop_full();
    test_ignore_rules();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
